// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA-facing drawing blocks.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic [7:0]        coord_x_t;
    typedef logic [6:0]        coord_y_t;
    typedef logic [2:0]        colour_t;
    typedef logic signed [9:0] coord_s_t;

    localparam coord_s_t SCREEN_W_S = coord_s_t'(SCREEN_W);
    localparam coord_s_t SCREEN_H_S = coord_s_t'(SCREEN_H);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PLOT,
        UPDATE,
        DONE
    } circle_state_t;

    // Index of the first octant at or after 'from' whose mask bit is set; 8 when none remain.
    function automatic logic [3:0] next_enabled(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] result;
        result = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if ((i >= int'(from)) && mask[i]) begin
                result = 4'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/octant_point.sv
// Maps an octant index plus circle offsets onto a signed screen point and
// reports whether that point lies inside the visible area.
module octant_point
    import vga_pkg::*;
(
    input  logic [2:0]        oct,
    input  logic signed [9:0] off_x,
    input  logic signed [9:0] off_y,
    input  logic [7:0]        centre_x,
    input  logic [6:0]        centre_y,
    output logic signed [9:0] pt_x,
    output logic signed [9:0] pt_y,
    output logic              on_screen
);

    coord_s_t cx_s;
    coord_s_t cy_s;

    assign cx_s = $signed({2'b00, centre_x});
    assign cy_s = $signed({3'b000, centre_y});

    // Reflect the first-octant offsets into the requested octant.
    always_comb begin
        pt_x = cx_s + off_x;
        pt_y = cy_s + off_y;
        case (oct)
            3'd0: begin pt_x = cx_s + off_x; pt_y = cy_s + off_y; end
            3'd1: begin pt_x = cx_s + off_y; pt_y = cy_s + off_x; end
            3'd2: begin pt_x = cx_s - off_x; pt_y = cy_s + off_y; end
            3'd3: begin pt_x = cx_s - off_y; pt_y = cy_s + off_x; end
            3'd4: begin pt_x = cx_s - off_x; pt_y = cy_s - off_y; end
            3'd5: begin pt_x = cx_s - off_y; pt_y = cy_s - off_x; end
            3'd6: begin pt_x = cx_s + off_y; pt_y = cy_s - off_x; end
            default: begin pt_x = cx_s + off_x; pt_y = cy_s - off_y; end
        endcase
    end

    assign on_screen = (pt_x >= 10'sd0) && (pt_x < SCREEN_W_S) &&
                       (pt_y >= 10'sd0) && (pt_y < SCREEN_H_S);

endmodule

// File: rtl/octant_circle.sv
// Midpoint circle rasteriser feeding the VGA adapter one pixel per cycle,
// with an octant mask selecting which symmetric octants are emitted.
// Optional macro OCTANT_CIRCLE_SKIP_MASKED_EN: PLOT visits only enabled
// octants; without it every iteration spends 8 PLOT cycles.
module octant_circle
    import vga_pkg::*;
#(
    parameter int CRIT_W = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       done,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    input  logic [7:0] octant_mask,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic signed [CRIT_W-1:0] CRIT_ONE  = CRIT_W'(1);
    localparam logic signed [CRIT_W-1:0] CRIT_ZERO = CRIT_W'(0);

    circle_state_t state_q, state_d;
    logic [2:0]    colour_q, colour_d;
    logic [7:0]    cx_q, cx_d;
    logic [6:0]    cy_q, cy_d;
    logic [7:0]    radius_q, radius_d;
    logic [7:0]    mask_q, mask_d;
    coord_s_t      ox_q, ox_d;
    coord_s_t      oy_q, oy_d;
    logic signed [CRIT_W-1:0] crit_q, crit_d;
    logic [2:0]    oct_q, oct_d;
    logic          done_q, done_d;
    logic          vga_plot_q, vga_plot_d;
    logic [7:0]    vga_x_q, vga_x_d;
    logic [6:0]    vga_y_q, vga_y_d;
    logic [2:0]    vga_colour_q, vga_colour_d;

    coord_s_t      pt_x, pt_y;
    logic          pt_on_screen;
    logic          pt_unused;

    coord_s_t      oy_new, ox_new;
    logic signed [CRIT_W-1:0] oy_w, diff_w;
`ifdef OCTANT_CIRCLE_SKIP_MASKED_EN
    logic [3:0]    nxt_oct;
`endif

    octant_point u_point (
        .oct       (oct_q),
        .off_x     (ox_q),
        .off_y     (oy_q),
        .centre_x  (cx_q),
        .centre_y  (cy_q),
        .pt_x      (pt_x),
        .pt_y      (pt_y),
        .on_screen (pt_on_screen)
    );

    // High bits of the point are only needed for the on-screen test.
    assign pt_unused = ^{pt_x[9:8], pt_y[9:7]};

    // Next-state, datapath and registered-output computation for the rasteriser.
    always_comb begin
        state_d      = state_q;
        colour_d     = colour_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        radius_d     = radius_q;
        mask_d       = mask_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        crit_d       = crit_q;
        oct_d        = oct_q;
        done_d       = 1'b0;
        vga_plot_d   = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        oy_new       = oy_q + 10'sd1;
        ox_new       = ox_q;
        oy_w         = CRIT_W'(oy_new);
        diff_w       = CRIT_ZERO;
`ifdef OCTANT_CIRCLE_SKIP_MASKED_EN
        nxt_oct      = 4'd8;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    colour_d = colour;
                    cx_d     = centre_x;
                    cy_d     = centre_y;
                    radius_d = radius;
                    mask_d   = octant_mask;
                    state_d  = INIT;
                end
            end

            INIT: begin
                ox_d   = $signed({2'b00, radius_q});
                oy_d   = 10'sd0;
                crit_d = CRIT_ONE - $signed({{(CRIT_W-8){1'b0}}, radius_q});
`ifdef OCTANT_CIRCLE_SKIP_MASKED_EN
                nxt_oct = next_enabled(mask_q, 4'd0);
                oct_d   = nxt_oct[2:0];
                state_d = (mask_q == 8'd0) ? DONE : PLOT;
`else
                oct_d   = 3'd0;
                state_d = PLOT;
`endif
            end

            PLOT: begin
                vga_plot_d   = mask_q[oct_q] && pt_on_screen;
                vga_x_d      = pt_x[7:0];
                vga_y_d      = pt_y[6:0];
                vga_colour_d = colour_q;
`ifdef OCTANT_CIRCLE_SKIP_MASKED_EN
                nxt_oct = next_enabled(mask_q, {1'b0, oct_q} + 4'd1);
                if (nxt_oct[3]) begin
                    state_d = UPDATE;
                end else begin
                    oct_d = nxt_oct[2:0];
                end
`else
                if (oct_q == 3'd7) begin
                    state_d = UPDATE;
                end else begin
                    oct_d = oct_q + 3'd1;
                end
`endif
            end

            UPDATE: begin
                if (crit_q <= CRIT_ZERO) begin
                    crit_d = crit_q + oy_w + oy_w + CRIT_ONE;
                end else begin
                    ox_new = ox_q - 10'sd1;
                    diff_w = oy_w - CRIT_W'(ox_new);
                    crit_d = crit_q + diff_w + diff_w + CRIT_ONE;
                end
                ox_d = ox_new;
                oy_d = oy_new;
                if (oy_new <= ox_new) begin
                    state_d = PLOT;
`ifdef OCTANT_CIRCLE_SKIP_MASKED_EN
                    nxt_oct = next_enabled(mask_q, 4'd0);
                    oct_d   = nxt_oct[2:0];
`else
                    oct_d   = 3'd0;
`endif
                end else begin
                    state_d = DONE;
                end
            end

            DONE: begin
                done_d = 1'b1;
                if (done_q && !start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and output registers; reset aborts any draw in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            colour_q     <= 3'd0;
            cx_q         <= 8'd0;
            cy_q         <= 7'd0;
            radius_q     <= 8'd0;
            mask_q       <= 8'd0;
            ox_q         <= 10'sd0;
            oy_q         <= 10'sd0;
            crit_q       <= CRIT_ZERO;
            oct_q        <= 3'd0;
            done_q       <= 1'b0;
            vga_plot_q   <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            colour_q     <= colour_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            radius_q     <= radius_d;
            mask_q       <= mask_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            crit_q       <= crit_d;
            oct_q        <= oct_d;
            done_q       <= done_d;
            vga_plot_q   <= vga_plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
        end
    end

    assign done       = done_q;
    assign vga_plot   = vga_plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_octant_circle.sv
// Directed testbench for octant_circle; expectations are hand-derived circle points and latencies.
module tb_octant_circle;

`ifdef OCTANT_CIRCLE_SKIP_MASKED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int MAX_CYC   = 5000;
    localparam int LOG_DEPTH = 64;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       done;
    logic [2:0] colour;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [7:0] octant_mask;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int checks;
    int errors;

    logic [7:0] px_log [LOG_DEPTH];
    logic [6:0] py_log [LOG_DEPTH];
    logic [2:0] pc_log [LOG_DEPTH];
    int         n_plots;

    octant_circle dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .done        (done),
        .colour      (colour),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .radius      (radius),
        .octant_mask (octant_mask),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, scramble inputs after the latch, log plots, and return cycles from latch to done (-1 on timeout).
    task automatic draw(input logic [7:0] cx, input logic [6:0] cy, input logic [7:0] r,
                        input logic [7:0] mask, input logic [2:0] col, output int lat);
        int cyc;
        n_plots = 0;
        lat = -1;
        cyc = 0;
        @(negedge clk);
        centre_x    = cx;
        centre_y    = cy;
        radius      = r;
        octant_mask = mask;
        colour      = col;
        start       = 1'b1;
        while (lat < 0 && cyc < MAX_CYC) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                centre_x    = 8'($urandom);
                centre_y    = 7'($urandom);
                radius      = 8'($urandom);
                octant_mask = 8'($urandom);
                colour      = 3'($urandom);
            end
            if (vga_plot === 1'b1) begin
                if (n_plots < LOG_DEPTH) begin
                    px_log[n_plots] = vga_x;
                    py_log[n_plots] = vga_y;
                    pc_log[n_plots] = vga_colour;
                end
                n_plots++;
            end
            if (done === 1'b1) lat = cyc - 1;
        end
    endtask

    task automatic end_draw();
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (vga_plot !== 1'b0) begin errors++; $display("[TB] FAIL reset_plot: got %b expected 0", vga_plot); end
        checks++; if (vga_x !== 8'd0) begin errors++; $display("[TB] FAIL reset_x: got %0d expected 0", vga_x); end
        checks++; if (vga_y !== 7'd0) begin errors++; $display("[TB] FAIL reset_y: got %0d expected 0", vga_y); end
        checks++; if (vga_colour !== 3'd0) begin errors++; $display("[TB] FAIL reset_colour: got %0d expected 0", vga_colour); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_radius_zero();
        int lat;
        draw(8'd80, 7'd60, 8'd0, 8'hFF, 3'b101, lat);
        checks++; if (lat !== 11) begin errors++; $display("[TB] FAIL r0_latency: got %0d expected 11", lat); end
        checks++; if (n_plots !== 8) begin errors++; $display("[TB] FAIL r0_plot_count: got %0d expected 8", n_plots); end
        for (int i = 0; i < 8; i++) begin
            if (i < n_plots) begin
                checks++;
                if (px_log[i] !== 8'd80 || py_log[i] !== 7'd60 || pc_log[i] !== 3'b101) begin
                    errors++;
                    $display("[TB] FAIL r0_pixel%0d: got (%0d,%0d,c%0d) expected (80,60,c5)", i, px_log[i], py_log[i], pc_log[i]);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL r0_done_hold: got %b expected 1", done); end
        checks++; if (vga_plot !== 1'b0) begin errors++; $display("[TB] FAIL r0_no_retrigger: got plot %b expected 0", vga_plot); end
        start = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL r0_done_clear: got %b expected 0", done); end
        @(negedge clk);
    endtask

    task automatic test_single_octant();
        int lat;
        int ex [3] = '{13, 13, 12};
        int ey [3] = '{10, 11, 12};
        draw(8'd10, 7'd10, 8'd3, 8'h01, 3'b010, lat);
        checks++; if (lat !== (SKIP ? 8 : 29)) begin errors++; $display("[TB] FAIL r3_latency: got %0d expected %0d", lat, SKIP ? 8 : 29); end
        checks++; if (n_plots !== 3) begin errors++; $display("[TB] FAIL r3_plot_count: got %0d expected 3", n_plots); end
        for (int i = 0; i < 3; i++) begin
            if (i < n_plots) begin
                checks++;
                if (int'(px_log[i]) != ex[i] || int'(py_log[i]) != ey[i] || pc_log[i] !== 3'b010) begin
                    errors++;
                    $display("[TB] FAIL r3_pixel%0d: got (%0d,%0d,c%0d) expected (%0d,%0d,c2)", i, px_log[i], py_log[i], pc_log[i], ex[i], ey[i]);
                end
            end
        end
        end_draw();
    endtask

    task automatic test_origin_clip();
        int lat;
        int bad;
        int ex [6] = '{1, 0, 0, 1, 1, 1};
        int ey [6] = '{0, 1, 1, 0, 1, 1};
        draw(8'd0, 7'd0, 8'd1, 8'hFF, 3'b111, lat);
        checks++; if (lat !== 20) begin errors++; $display("[TB] FAIL origin_latency: got %0d expected 20", lat); end
        checks++; if (n_plots !== 6) begin errors++; $display("[TB] FAIL origin_plot_count: got %0d expected 6", n_plots); end
        for (int i = 0; i < 6; i++) begin
            if (i < n_plots) begin
                checks++;
                if (int'(px_log[i]) != ex[i] || int'(py_log[i]) != ey[i]) begin
                    errors++;
                    $display("[TB] FAIL origin_pixel%0d: got (%0d,%0d) expected (%0d,%0d)", i, px_log[i], py_log[i], ex[i], ey[i]);
                end
            end
        end
        bad = 0;
        for (int i = 0; i < LOG_DEPTH; i++) begin
            if (i < n_plots && (px_log[i] >= 8'd160 || py_log[i] >= 7'd120)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL origin_range: got %0d off-screen plots expected 0", bad); end
        end_draw();
    endtask

    task automatic test_corner_clip();
        int lat;
        draw(8'd159, 7'd119, 8'd200, 8'hFF, 3'b001, lat);
        checks++; if (lat < 2 || ((lat - 2) % 9) != 0) begin errors++; $display("[TB] FAIL corner_latency: got %0d expected 2+9k", lat); end
        checks++; if (n_plots !== 0) begin errors++; $display("[TB] FAIL corner_no_wrap: got %0d plots expected 0", n_plots); end
        end_draw();
    endtask

    task automatic test_mask_zero();
        int lat;
        draw(8'd50, 7'd50, 8'd3, 8'h00, 3'b011, lat);
        checks++; if (lat !== (SKIP ? 2 : 29)) begin errors++; $display("[TB] FAIL mask0_latency: got %0d expected %0d", lat, SKIP ? 2 : 29); end
        checks++; if (n_plots !== 0) begin errors++; $display("[TB] FAIL mask0_plot_count: got %0d expected 0", n_plots); end
        end_draw();
    endtask

    task automatic test_reset_mid_draw();
        int lat;
        int waited;
        int stray;
        @(negedge clk);
        centre_x    = 8'd80;
        centre_y    = 7'd60;
        radius      = 8'd50;
        octant_mask = 8'hFF;
        colour      = 3'b110;
        start       = 1'b1;
        waited = 0;
        while (vga_plot !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (vga_plot !== 1'b1) begin errors++; $display("[TB] FAIL abort_reach_plot: got %b expected 1", vga_plot); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (vga_plot !== 1'b0) begin errors++; $display("[TB] FAIL abort_plot_async: got %b expected 0", vga_plot); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done_async: got %b expected 0", done); end
        start = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (vga_plot !== 1'b0) stray++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (vga_plot !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL abort_stray_plots: got %0d expected 0", stray); end
        draw(8'd20, 7'd30, 8'd2, 8'h80, 3'b111, lat);
        checks++; if (lat !== (SKIP ? 6 : 20)) begin errors++; $display("[TB] FAIL restart_latency: got %0d expected %0d", lat, SKIP ? 6 : 20); end
        checks++; if (n_plots !== 2) begin errors++; $display("[TB] FAIL restart_plot_count: got %0d expected 2", n_plots); end
        if (n_plots >= 1) begin
            checks++;
            if (px_log[0] !== 8'd22 || py_log[0] !== 7'd30 || pc_log[0] !== 3'b111) begin
                errors++; $display("[TB] FAIL restart_pixel0: got (%0d,%0d,c%0d) expected (22,30,c7)", px_log[0], py_log[0], pc_log[0]);
            end
        end
        if (n_plots >= 2) begin
            checks++;
            if (px_log[1] !== 8'd22 || py_log[1] !== 7'd29 || pc_log[1] !== 3'b111) begin
                errors++; $display("[TB] FAIL restart_pixel1: got (%0d,%0d,c%0d) expected (22,29,c7)", px_log[1], py_log[1], pc_log[1]);
            end
        end
        end_draw();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        n_plots     = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        colour      = 3'd0;
        centre_x    = 8'd0;
        centre_y    = 7'd0;
        radius      = 8'd0;
        octant_mask = 8'd0;
        test_reset();
        test_radius_zero();
        test_single_octant();
        test_origin_clip();
        test_corner_clip();
        test_mask_zero();
        test_reset_mid_draw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/octant_circle.md
Name: octant_circle

Overview:
- Midpoint (Bresenham) circle rasteriser.
- Sits directly upstream of the VGA adapter: drives its x/y/colour/plot inputs one pixel per cycle.
- An 8-bit octant mask selects which of the 8 symmetric octants are emitted. This lets the Reuleaux-triangle top level build arcs from repeated invocations.
- Uses a start/done handshake.

Parameters:
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are suppressed.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are suppressed.
- CRIT_W, 12, signed width of the decision variable.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; level-held by the requester until done is seen.
- done  out  1  drawing complete; held high until start deasserts.
- colour  in  3  pixel colour, latched at start.
- centre_x  in  8  centre column, latched at start.
- centre_y  in  7  centre row, latched at start.
- radius  in  8  radius in pixels, latched at start.
- octant_mask  in  8  bit i enables octant i, latched at start.
- vga_x  out  8  pixel column.
- vga_y  out  7  pixel row.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write strobe, one cycle per pixel.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - done, vga_plot, vga_x, vga_y, vga_colour all 0.
  - Internal offsets and crit cleared.
  - Reset mid-draw aborts immediately; no further plots.
- States: IDLE, INIT, PLOT, UPDATE, DONE.
- IDLE: on start=1, latch all inputs and go to INIT. Inputs changing after that cycle are ignored.
- INIT (1 cycle): offset_x=radius, offset_y=0, crit=1-radius, oct=0. Go to PLOT.
- PLOT (1 cycle per octant, oct 0..7). Candidate point, computed in 10-bit signed arithmetic:
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx-ox, cy+oy)
  - 3: (cx-oy, cy+ox)
  - 4: (cx-ox, cy-oy)
  - 5: (cx-oy, cy-ox)
  - 6: (cx+oy, cy-ox)
  - 7: (cx+ox, cy-oy)
- PLOT output rules:
  - vga_plot=1 only if octant_mask[oct]=1 and 0<=x<SCREEN_W and 0<=y<SCREEN_H.
  - vga_x/vga_y carry the truncated candidate in the same cycle (registered outputs, valid when vga_plot=1).
  - After oct=7, go to UPDATE.
- UPDATE (1 cycle), vga_plot=0:
  - oy+=1.
  - If crit<=0: crit += 2*oy_new+1.
  - Else: ox-=1 and crit += 2*(oy_new-ox_new)+1.
  - Then, if oy_new<=ox_new, go to PLOT with oct=0; else go to DONE.
- DONE: done=1, vga_plot=0. When start=0, go to IDLE and drop done next cycle. Holding start high keeps done high; no re-trigger.
- start while busy (INIT/PLOT/UPDATE) is ignored.
- Latency: 1 (INIT) + iterations*9 + 1 cycles from the latch cycle to done.
- Boundary cases:
  - radius=0: one iteration, 8 plots of the centre, then done.
  - octant_mask=0: full timing, no plots.
  - Duplicate pixels on octant boundaries are emitted, not deduplicated.
  - Negative or overflowed coordinates are never plotted; no wrap-around onto the screen.

Optional Feature:
- Macro: OCTANT_CIRCLE_SKIP_MASKED_EN.
- Defined: PLOT steps only through enabled octants. Masked octants consume no cycles. octant_mask=0 goes INIT → DONE directly.
- Undefined: fixed 8 PLOT cycles per iteration, as above.
- Pixel sequence and order are identical in both modes; only timing differs.

Decomposition:
- Shared package vga_pkg:
  - SCREEN_W/SCREEN_H constants.
  - coord_x_t (8b), coord_y_t (7b), colour_t (3b).
  - Signed 10-bit coord_s_t.
  - State enum circle_state_t.
- Sub-module octant_point: combinational octant index + offsets + centre → signed point and on-screen flag. Reused by the Reuleaux top level.

Test Plan:
- Reset then start, centre (80,60), r=0, mask FF → 8 plots at (80,60); done on cycle 11 after latch; done holds while start=1 and clears 1 cycle after start=0.
- Centre (10,10), r=3, mask 01, colour 3'b010 → exactly (13,10), (13,11), (12,12) with colour 010; 3 iterations; done after 29 cycles.
- Centre (0,0), r=1, mask FF → only on-screen points plotted ((1,0), (0,1), (1,1) plus duplicates); no plot with x or y out of range.
- Centre (159,119), r=200, mask FF → every emitted pixel has x<160, y<120; no wrapped coordinates.
- Assert rst_n=0 mid-PLOT → vga_plot and done go 0 asynchronously; after release, a new start draws correctly from scratch.
- With OCTANT_CIRCLE_SKIP_MASKED_EN, repeat the r=3 mask=01 case → same 3 pixels; done after 1+3*2+1 cycles. Mask 00 → done with zero plots.
